// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, requester ids
// and the width of the memory latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} arb_state_t;

  typedef enum logic {PORT_CPU, PORT_EXT} port_t;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational grant: a single requester always wins; on a tie
// either the core wins (cpu_prio) or the port not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  input  logic       cpu_prio,
  output port_t      gnt,
  output logic       any_req
);

  // req[0] is the core, req[1] is the external loader
  always_comb begin
    any_req = |req;
    gnt     = PORT_CPU;
    if (req == 2'b10) begin
      gnt = PORT_EXT;
    end else if (req == 2'b11 && !cpu_prio && last_grant == PORT_CPU) begin
      gnt = PORT_EXT;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory between the core and the external loader,
// running each access as IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ready,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  arb_state_t           state;
  port_t                last_grant;
  port_t                owner;
  port_t                gnt;
  logic                 any_req;
  logic                 acc_we;
  logic [LAT_CNT_W-1:0] lat_cnt;

  rr_arb2 u_arb (
    .req        ({ext_req, cpu_req}),
    .last_grant (last_grant),
    .cpu_prio   (CPU_PRIO != 0),
    .gnt        (gnt),
    .any_req    (any_req)
  );

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // Valid/ready: a requester holds req (and its we/addr/wdata) until its
  // one-cycle ready pulse; request fields are sampled only in IDLE, and a
  // req still high in the IDLE cycle after ready starts a new access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= PORT_EXT;
      owner      <= PORT_CPU;
      acc_we     <= 1'b0;
      lat_cnt    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ready  <= 1'b0;
      ext_ready  <= 1'b0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner      <= gnt;
            last_grant <= gnt;
            mem_en     <= 1'b1;
            state      <= S_ISSUE;
            if (gnt == PORT_CPU) begin
              acc_we    <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end else begin
              acc_we    <= ext_we;
              mem_we    <= ext_we;
              mem_addr  <= ext_addr;
              mem_wdata <= ext_wdata;
            end
          end
        end
        S_ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          lat_cnt <= LAT_CNT_W'(MEM_LAT - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is valid in the last WAIT cycle, MEM_LAT after mem_en
          if (lat_cnt == '0) begin
            state <= S_DONE;
            if (owner == PORT_CPU) begin
              cpu_ready <= 1'b1;
              if (!acc_we) cpu_rdata <= mem_rdata;
            end else begin
              ext_ready <= 1'b1;
              if (!acc_we) ext_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_DONE: begin
          cpu_ready <= 1'b0;
          ext_ready <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: instance 0 is round-robin with
// MEM_LAT=1, instance 1 is core-priority with MEM_LAT=3.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req[2], cpu_we[2], ext_req[2], ext_we[2];
  logic        cpu_ready[2], ext_ready[2], mem_en[2], mem_we[2], busy[2];
  logic [31:0] cpu_addr[2], cpu_wdata[2], cpu_rdata[2];
  logic [31:0] ext_addr[2], ext_wdata[2], ext_rdata[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic [1:0]  fsm_state[2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .CPU_PRIO(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ready(cpu_ready[0]), .cpu_rdata(cpu_rdata[0]),
    .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]), .ext_wdata(ext_wdata[0]),
    .ext_ready(ext_ready[0]), .ext_rdata(ext_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .fsm_state(fsm_state[0])
  );

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .CPU_PRIO(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ready(cpu_ready[1]), .cpu_rdata(cpu_rdata[1]),
    .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]), .ext_wdata(ext_wdata[1]),
    .ext_ready(ext_ready[1]), .ext_rdata(ext_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .fsm_state(fsm_state[1])
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  logic [3:0]  m_cnt[2];
  logic [31:0] m_data[2];

  // Read data appears only in the single cycle MEM_LAT after the strobe
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_cnt[i] <= 4'd0;
      end else if (mem_en[i] && !mem_we[i]) begin
        m_cnt[i]  <= (i == 0) ? 4'd1 : 4'd3;
        m_data[i] <= mem_val(mem_addr[i]);
      end else if (m_cnt[i] != 4'd0) begin
        m_cnt[i] <= m_cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = (m_cnt[i] == 4'd1) ? m_data[i] : 32'hBAD0_BAD0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int idx, input bit ext, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (ext) begin
      ext_req[idx] = 1'b1; ext_we[idx] = we; ext_addr[idx] = addr; ext_wdata[idx] = wdata;
    end else begin
      cpu_req[idx] = 1'b1; cpu_we[idx] = we; cpu_addr[idx] = addr; cpu_wdata[idx] = wdata;
    end
  endtask

  // Both ports requesting continuously; grant order is popped from exp_q
  task automatic run_pair(input int idx, input int n, input int lat);
    int  c;
    logic [31:0] exp_port;
    drive_req(idx, 1'b0, 1'b0, 32'h200, 32'h0);
    drive_req(idx, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int k = 0; k < n; k++) begin
      c = 0;
      while (!(cpu_ready[idx] || ext_ready[idx]) && c < 40) begin
        tick();
        c++;
      end
      if (!(cpu_ready[idx] || ext_ready[idx])) begin
        check("pair_timeout", 32'(c), 32'(lat + 2));
        cpu_req[idx] = 1'b0;
        ext_req[idx] = 1'b0;
        return;
      end
      exp_port = exp_q.pop_front();
      check("pair_grant", 32'(ext_ready[idx]), exp_port);
      check("pair_rdata", (exp_port == 0) ? cpu_rdata[idx] : ext_rdata[idx],
            mem_val((exp_port == 0) ? 32'h200 : 32'h300));
      if (k > 0) check("pair_gap", 32'(c + 1), 32'(lat + 3));
      if (k == n - 1) begin
        cpu_req[idx] = 1'b0;
        ext_req[idx] = 1'b0;
      end
      tick();
      check("pair_ready_pulse", 32'(cpu_ready[idx] | ext_ready[idx]), 32'd0);
    end
    repeat (lat + 4) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      ext_req[i] = 1'b0; ext_we[i] = 1'b0; ext_addr[i] = '0; ext_wdata[i] = '0;
    end

    // 1. reset with both requests high, then the core wins the first tie
    for (int i = 0; i < 2; i++) begin
      drive_req(i, 1'b0, 1'b0, 32'h10, 32'h0);
      drive_req(i, 1'b1, 1'b0, 32'h20, 32'h0);
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_mem_en", 32'(mem_en[i]), 32'd0);
      check("rst_mem_we", 32'(mem_we[i]), 32'd0);
      check("rst_mem_addr", mem_addr[i], 32'd0);
      check("rst_mem_wdata", mem_wdata[i], 32'd0);
      check("rst_ready", 32'(cpu_ready[i] | ext_ready[i]), 32'd0);
      check("rst_cpu_rdata", cpu_rdata[i], 32'd0);
      check("rst_ext_rdata", ext_rdata[i], 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      check("first_tie_addr", mem_addr[i], 32'h10);
      check("first_tie_en", 32'(mem_en[i]), 32'd1);
      cpu_req[i] = 1'b0;
      ext_req[i] = 1'b0;
    end
    repeat (8) tick();

    // 2. core read, MEM_LAT=1
    drive_req(0, 1'b0, 1'b0, 32'h40, 32'h0);
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("rd_mem_en", 32'(mem_en[0]), 32'(t == 1));
      check("rd_cpu_ready", 32'(cpu_ready[0]), 32'(t == 3));
      check("rd_busy", 32'(busy[0]), 32'(t <= 3));
      if (t == 1) check("rd_mem_addr", mem_addr[0], 32'h40);
      if (t == 1) check("rd_mem_we", 32'(mem_we[0]), 32'd0);
      if (t == 3) begin
        check("rd_cpu_rdata", cpu_rdata[0], 32'hDEAD_BEEF);
        cpu_req[0] = 1'b0;
      end
    end

    // 3. external write
    drive_req(0, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("wr_mem_en", 32'(mem_en[0]), 32'(t == 1));
      check("wr_mem_we", 32'(mem_we[0]), 32'(t == 1));
      check("wr_ext_ready", 32'(ext_ready[0]), 32'(t == 3));
      if (t <= 3) check("wr_mem_addr", mem_addr[0], 32'h100);
      if (t <= 3) check("wr_mem_wdata", mem_wdata[0], 32'h1234_5678);
      if (t == 3) begin
        check("wr_ext_rdata", ext_rdata[0], 32'd0);
        check("wr_cpu_ready", 32'(cpu_ready[0]), 32'd0);
        ext_req[0] = 1'b0;
      end
    end
    repeat (2) tick();

    // 4. contention: round-robin, then core priority
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    run_pair(0, 4, 1);
    repeat (4) exp_q.push_back(0);
    run_pair(1, 4, 3);

    // 5. MEM_LAT=3 read with the address changing mid-access
    drive_req(1, 1'b0, 1'b0, 32'h80, 32'h0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 2) cpu_addr[1] = 32'hFFC;
      check("lat3_busy", 32'(busy[1]), 32'(t <= 5));
      check("lat3_ready", 32'(cpu_ready[1]), 32'(t == 5));
      check("lat3_mem_en", 32'(mem_en[1]), 32'(t == 1));
      if (t <= 5) check("lat3_mem_addr", mem_addr[1], 32'h80);
      if (t == 5) begin
        check("lat3_rdata", cpu_rdata[1], mem_val(32'h80));
        cpu_req[1] = 1'b0;
      end
    end

    // 6. reset during WAIT abandons the access
    drive_req(1, 1'b0, 1'b0, 32'h44, 32'h0);
    tick();
    tick();
    check("abort_in_wait", 32'(fsm_state[1]), 32'd2);
    reset = 1'b1;
    cpu_req[1] = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_state", 32'(fsm_state[1]), 32'd0);
    check("abort_busy", 32'(busy[1]), 32'd0);
    check("abort_mem_en", 32'(mem_en[1]), 32'd0);
    check("abort_mem_addr", mem_addr[1], 32'd0);
    check("abort_cpu_rdata", cpu_rdata[1], 32'd0);
    for (int t = 0; t < 4; t++) begin
      check("abort_no_ready", 32'(cpu_ready[1]), 32'd0);
      tick();
    end
    drive_req(1, 1'b1, 1'b0, 32'h300, 32'h0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("post_ext_ready", 32'(ext_ready[1]), 32'(t == 5));
      if (t == 5) begin
        check("post_ext_rdata", ext_rdata[1], mem_val(32'h300));
        ext_req[1] = 1'b0;
      end
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
